// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and defaults for the round-robin grant arbiter and its picker.
package arb_pkg;

  localparam int N_DEF        = 8;
  localparam int IDX_W_DEF    = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_grant_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after ptr (wrapping),
// returned as one-hot, binary index and an any-request flag.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick_oh,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_any
);

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  logic [2*N-1:0] rot_dbl_s;
  logic [N-1:0]   rot_s;
  logic [N-1:0]   rot_oh_s;
  logic [2*N-1:0] back_dbl_s;

  // rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
  always_comb begin
    rot_dbl_s  = {req, req} >> ptr;
    rot_s      = rot_dbl_s[N-1:0];
    rot_oh_s   = rot_s & (~rot_s + ONE_N);
    back_dbl_s = {rot_oh_s, rot_oh_s} << ptr;
    pick_oh    = back_dbl_s[2*N-1:N];
    pick_any   = |req;
  end

  // one-hot to binary
  always_comb begin
    pick_idx = {IDX_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (pick_oh[i]) begin
        pick_idx = pick_idx | IDX_W'(i);
      end else begin
        pick_idx = pick_idx;
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant and binary index.
// Optional hold-timeout preemption is built when ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF
`ifdef ARB_TIMEOUT_EN
  , parameter int MAX_HOLD = MAX_HOLD_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;

  logic [N-1:0]     pick_req_s;
  logic [IDX_W-1:0] pick_ptr_s;
  logic [N-1:0]     pick_oh_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic             owner_req_s;
  logic             timeout_s;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              preempt_q, preempt_d;
`endif

  // While granted, search the others starting just past the owner so it goes last
  assign pick_req_s  = (state_q == ARB_GRANT) ? (req & ~gnt_q) : req;
  assign pick_ptr_s  = (state_q == ARB_GRANT) ? (gnt_idx_q + IDX_W'(1)) : ptr_q;
  assign owner_req_s = |(req & gnt_q);

`ifdef ARB_TIMEOUT_EN
  assign timeout_s = (hold_cnt_q == HOLD_LAST) && owner_req_s && en && pick_any_s;
`else
  assign timeout_s = 1'b0;
`endif

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (pick_req_s),
    .ptr      (pick_ptr_s),
    .pick_oh  (pick_oh_s),
    .pick_idx (pick_idx_s),
    .pick_any (pick_any_s)
  );

  // next-state and next-output computation
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (en && pick_any_s) begin
          state_d   = ARB_GRANT;
          gnt_d     = pick_oh_s;
          gnt_idx_d = pick_idx_s;
        end else begin
          state_d = ARB_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = {HOLD_W{1'b0}};
`endif
      end
      ARB_GRANT: begin
        if (!owner_req_s || timeout_s) begin
          ptr_d = pick_ptr_s;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = {HOLD_W{1'b0}};
          preempt_d  = timeout_s;
`endif
          if (en && pick_any_s) begin
            state_d   = ARB_GRANT;
            gnt_d     = pick_oh_s;
            gnt_idx_d = pick_idx_s;
          end else begin
            state_d   = ARB_IDLE;
            gnt_d     = {N{1'b0}};
            gnt_idx_d = {IDX_W{1'b0}};
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
`endif
          state_d = ARB_GRANT;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        gnt_d     = {N{1'b0}};
        gnt_idx_d = {IDX_W{1'b0}};
      end
    endcase
    gnt_valid_d = |gnt_d;
  end

  // state and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= {IDX_W{1'b0}};
      gnt_q       <= {N{1'b0}};
      gnt_idx_q   <= {IDX_W{1'b0}};
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // hold counter and preempt pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= {HOLD_W{1'b0}};
      preempt_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule
